// File: rtl/pixel_pack_writer_pkg.sv
// rtl/pixel_pack_writer_pkg.sv - shared frame geometry, write-client state encodings and FIFO entry type
package pixel_pack_writer_pkg;

    // Frame geometry and word widths shared with the frame-buffer read side.
    localparam int LOG_WIDTH    = 3;
    localparam int LOG_HEIGHT   = 2;
    localparam int LOG_TRUNC    = 18;
    localparam int LOG_MEM      = 2 * LOG_TRUNC;
    localparam int IMAGE_WIDTH  = 8;
    localparam int IMAGE_HEIGHT = 4;

    // Write-client handshake states, reusable by any memory_interface writer.
    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_WAIT = 1'b1
    } wr_state_t;

    // One queued write: packed pixel pair plus the coordinates of its even pixel.
    typedef struct packed {
        logic [LOG_MEM-1:0]    data;
        logic [LOG_WIDTH-1:0]  x;
        logic [LOG_HEIGHT-1:0] y;
    } wr_word_t;

    localparam int WR_WORD_W = $bits(wr_word_t);

endpackage

// File: rtl/pixel_pack_writer_fifo.sv
// rtl/pixel_pack_writer_fifo.sv - generic synchronous FIFO with first-word fall-through read
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   push, push_data  write request and data; ignored while full
//   pop, pop_data    read request; pop_data always shows the head entry
//   full, empty      occupancy flags
//   count            number of stored entries (0..DEPTH)
module pixel_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int LOG_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic                 full,
    output logic                 empty,
    output logic [LOG_DEPTH:0]   count
);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [LOG_DEPTH-1:0] r_wr_ptr;
    logic [LOG_DEPTH-1:0] r_rd_ptr;
    logic [LOG_DEPTH:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    // Full is judged on the current occupancy, so a push into a full FIFO is
    // refused even when a pop happens on the same edge.
    assign full      = (r_count == (LOG_DEPTH+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + LOG_DEPTH'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (LOG_DEPTH+1)'(1);
                2'b01:   r_count <= r_count - (LOG_DEPTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_pack_writer.sv
// rtl/pixel_pack_writer.sv - packs raster pixel pairs into memory words and issues flag/done writes
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   frame_flag          start-of-frame pulse: restarts coordinates, clears overflow
//   pixel_in/valid      raster-order pixel stream
//   wr_flag             one-cycle write request to memory_interface
//   wr                  constant write direction
//   wr_x, wr_y          coordinates of the even pixel of the outstanding word
//   pixel_write         {even pixel, odd pixel}
//   done_wr             memory accepted the outstanding write
//   overflow            sticky: a packed word was dropped this frame
//   busy                words queued or a write outstanding
module pixel_pack_writer
    import pixel_pack_writer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int LOG_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_flag,
    input  logic [LOG_TRUNC-1:0]  pixel_in,
    input  logic                  pixel_valid,
    output logic                  wr_flag,
    output logic                  wr,
    output logic [LOG_WIDTH-1:0]  wr_x,
    output logic [LOG_HEIGHT-1:0] wr_y,
    output logic [LOG_MEM-1:0]    pixel_write,
    input  logic                  done_wr,
    output logic                  overflow,
    output logic                  busy
);

    logic [LOG_WIDTH-1:0]  r_cx;
    logic [LOG_HEIGHT-1:0] r_cy;
    logic [LOG_TRUNC-1:0]  r_hold;
    logic [LOG_WIDTH-1:0]  r_hold_x;
    logic [LOG_HEIGHT-1:0] r_hold_y;
    logic                  r_overflow;
    logic                  r_wr_flag;
    logic [LOG_WIDTH-1:0]  r_wr_x;
    logic [LOG_HEIGHT-1:0] r_wr_y;
    logic [LOG_MEM-1:0]    r_pixel_write;
    wr_state_t             r_state;
    wr_state_t             w_state_next;

    logic [LOG_WIDTH-1:0]  w_px;
    logic [LOG_HEIGHT-1:0] w_py;
    logic                  w_push_req;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [LOG_DEPTH:0]    w_count;
    wr_word_t              w_push_word;
    wr_word_t              w_pop_word;

    // A frame_flag coinciding with a valid pixel makes that pixel (0,0).
    assign w_px = frame_flag ? '0 : r_cx;
    assign w_py = frame_flag ? '0 : r_cy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (pixel_valid) begin
            if (w_px == LOG_WIDTH'(IMAGE_WIDTH - 1)) begin
                r_cx <= '0;
                r_cy <= (w_py == LOG_HEIGHT'(IMAGE_HEIGHT - 1)) ? '0 : w_py + LOG_HEIGHT'(1);
            end else begin
                r_cx <= w_px + LOG_WIDTH'(1);
                r_cy <= w_py;
            end
        end else if (frame_flag) begin
            r_cx <= '0;
            r_cy <= '0;
        end
    end

    // The even pixel waits in hold; a frame restart discards it implicitly
    // because the next pixel is even again and overwrites it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold   <= '0;
            r_hold_x <= '0;
            r_hold_y <= '0;
        end else if (pixel_valid && !w_px[0]) begin
            r_hold   <= pixel_in;
            r_hold_x <= w_px;
            r_hold_y <= w_py;
        end
    end

    assign w_push_req       = pixel_valid & w_px[0];
    assign w_push_word.data = {r_hold, pixel_in};
    assign w_push_word.x    = r_hold_x;
    assign w_push_word.y    = r_hold_y;

    pixel_fifo #(
        .WIDTH     (WR_WORD_W),
        .DEPTH     (DEPTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push_req),
        .push_data (w_push_word),
        .pop       (w_pop),
        .pop_data  (w_pop_word),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // A pair arriving while the FIFO is full is lost; the frame restart is the
    // only way to clear the record of it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (frame_flag) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= WR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            WR_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (done_wr) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = WR_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = WR_IDLE;
            end
        endcase
    end

    // Output registers load only on a pop, so they stay stable for the whole
    // time a write is outstanding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_flag     <= 1'b0;
            r_wr_x        <= '0;
            r_wr_y        <= '0;
            r_pixel_write <= '0;
        end else begin
            r_wr_flag <= w_pop;
            if (w_pop) begin
                r_wr_x        <= w_pop_word.x;
                r_wr_y        <= w_pop_word.y;
                r_pixel_write <= w_pop_word.data;
            end
        end
    end

    assign wr_flag     = r_wr_flag;
    assign wr          = 1'b1;
    assign wr_x        = r_wr_x;
    assign wr_y        = r_wr_y;
    assign pixel_write = r_pixel_write;
    assign overflow    = r_overflow;
    assign busy        = (w_count != '0) | (r_state == WR_WAIT);

endmodule

// File: tb/tb_pixel_pack_writer.sv
// tb/tb_pixel_pack_writer.sv - randomized and directed bench with a queue-level reference model
module tb_pixel_pack_writer;
    import pixel_pack_writer_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = IMAGE_WIDTH;
    localparam int H     = IMAGE_HEIGHT;

    typedef struct {
        int           x;
        int           y;
        logic [35:0]  data;
    } word_t;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  frame_flag = 1'b0;
    logic [LOG_TRUNC-1:0]  pixel_in = '0;
    logic                  pixel_valid = 1'b0;
    logic                  wr_flag;
    logic                  wr;
    logic [LOG_WIDTH-1:0]  wr_x;
    logic [LOG_HEIGHT-1:0] wr_y;
    logic [LOG_MEM-1:0]    pixel_write;
    logic                  done_wr = 1'b0;
    logic                  overflow;
    logic                  busy;

    int n_checks = 0;
    int n_pass   = 0;

    pixel_pack_writer #(.DEPTH(DEPTH), .LOG_DEPTH(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_flag  (frame_flag),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .wr_flag     (wr_flag),
        .wr          (wr),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .pixel_write (pixel_write),
        .done_wr     (done_wr),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: words waiting in a queue, one outstanding write at most.
    word_t       mq[$];
    bit          m_out;
    bit          m_flag;
    int          m_x, m_y;
    logic [35:0] m_data;
    bit          m_ovf;
    int          m_n;
    logic [17:0] m_hold;
    int          m_hx, m_hy;
    int          m_sz;
    bit          m_pop;
    word_t       m_w;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_out = 0; m_flag = 0; m_x = 0; m_y = 0; m_data = '0; m_ovf = 0;
            m_n = 0; m_hold = '0; m_hx = 0; m_hy = 0;
        end else begin
            m_sz  = mq.size();
            m_pop = 0;
            if (!m_out) m_pop = (m_sz > 0);
            else if (done_wr) begin
                if (m_sz > 0) m_pop = 1;
                else m_out = 0;
            end
            if (m_pop) begin
                m_w = mq.pop_front();
                m_x = m_w.x; m_y = m_w.y; m_data = m_w.data;
                m_out = 1;
            end
            m_flag = m_pop;
            if (frame_flag) begin
                m_n = 0;
                m_ovf = 0;
            end
            if (pixel_valid) begin
                if ((m_n % W) % 2 == 0) begin
                    m_hold = pixel_in; m_hx = m_n % W; m_hy = (m_n / W) % H;
                end else if (m_sz == DEPTH) begin
                    m_ovf = 1;
                end else begin
                    m_w.x = m_hx; m_w.y = m_hy; m_w.data = {m_hold, pixel_in};
                    mq.push_back(m_w);
                end
                m_n = (m_n + 1) % (W * H);
            end
        end
    end

    // Per-cycle comparison and capture of every issued word.
    word_t log_q[$];
    word_t l_w;
    always @(negedge clock) begin
        chk("wr", wr, 1);
        chk("wr_flag", wr_flag, m_flag);
        chk("wr_x", wr_x, m_x);
        chk("wr_y", wr_y, m_y);
        chk("pixel_write", pixel_write, m_data);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, (mq.size() != 0) || m_out);
        if (wr_flag) begin
            l_w.x = wr_x; l_w.y = wr_y; l_w.data = pixel_write;
            log_q.push_back(l_w);
        end
    end

    // Automatic memory responder: done_wr a random delay after each wr_flag.
    bit resp_en = 0;
    int rmin = 1, rmax = 1;
    int r_cnt = 0;
    bit r_wait = 0;
    initial forever begin
        @(posedge clock); #1;
        if (!reset) r_wait = 0;
        if (resp_en) begin
            done_wr = 0;
            if (wr_flag) begin
                r_cnt = $urandom_range(rmax, rmin);
                r_wait = 1;
            end
            if (r_wait) begin
                if (r_cnt <= 1) begin done_wr = 1; r_wait = 0; end
                else r_cnt--;
            end
        end
    end

    task automatic step(input logic ff, input logic pv, input logic [17:0] px);
        frame_flag = ff; pixel_valid = pv; pixel_in = px;
        @(posedge clock); #2;
        frame_flag = 0; pixel_valid = 0;
        if (!resp_en) done_wr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 18'h0);
    endtask

    task automatic drain(input int max);
        int k = 0;
        while ((busy || r_wait) && k < max) begin idle(1); k++; end
        idle(2);
        chk("drain_timeout", busy, 0);
    endtask

    logic [17:0] p[16];
    logic [35:0] e36;

    initial begin
        // Reset
        reset = 0;
        repeat (3) @(posedge clock);
        #2;
        chk("rst_wr_flag", wr_flag, 0);
        chk("rst_pixel_write", pixel_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr", wr, 1);
        reset = 1;
        idle(2);

        // Single pair, manual done
        log_q.delete();
        step(0, 1, 18'h12345);
        step(0, 1, 18'h0ABCD);
        @(negedge clock);
        chk("pair_lat1", wr_flag, 0);
        @(posedge clock); #2;
        @(negedge clock);
        e36 = {18'h12345, 18'h0ABCD};
        chk("pair_flag", wr_flag, 1);
        chk("pair_data", pixel_write, e36);
        chk("pair_x", wr_x, 0);
        chk("pair_y", wr_y, 0);
        @(posedge clock); #2;
        idle(3);
        chk("pair_hold_data", pixel_write, e36);
        chk("pair_hold_flag", wr_flag, 0);
        chk("pair_busy", busy, 1);
        done_wr = 1;
        step(0, 0, 18'h0);
        idle(1);
        chk("pair_done_busy", busy, 0);

        // Spurious done in IDLE
        for (int i = 0; i < 3; i++) begin
            done_wr = 1;
            step(0, 0, 18'h0);
            @(negedge clock);
            chk("spur_flag", wr_flag, 0);
            chk("spur_busy", busy, 0);
        end

        // Row wrap
        resp_en = 1; rmin = 1; rmax = 1;
        step(1, 0, 18'h0);
        log_q.delete();
        for (int i = 0; i < W + 2; i++) begin
            p[i] = 18'($urandom);
            step(0, 1, p[i]);
        end
        drain(100);
        chk("wrap_count", log_q.size(), W / 2 + 1);
        if (log_q.size() == W / 2 + 1) begin
            chk("wrap_pen_x", log_q[W/2-1].x, W - 2);
            chk("wrap_pen_y", log_q[W/2-1].y, 0);
            chk("wrap_last_x", log_q[W/2].x, 0);
            chk("wrap_last_y", log_q[W/2].y, 1);
            chk("wrap_last_data", log_q[W/2].data, {p[W], p[W+1]});
        end

        // Stall and overflow
        resp_en = 0; done_wr = 0;
        step(1, 0, 18'h0);
        log_q.delete();
        for (int i = 0; i < 2 * (DEPTH + 2); i++) begin
            p[i] = 18'($urandom);
            step(0, 1, p[i]);
        end
        idle(3);
        chk("stall_ovf", overflow, 1);
        chk("stall_busy", busy, 1);
        chk("stall_issued", log_q.size(), 1);
        for (int i = 0; i <= DEPTH; i++) begin
            done_wr = 1;
            step(0, 0, 18'h0);
            @(negedge clock);
            chk("stall_b2b_flag", wr_flag, (i < DEPTH) ? 1 : 0);
            @(posedge clock); #2;
        end
        chk("stall_words", log_q.size(), DEPTH + 1);
        if (log_q.size() == DEPTH + 1) begin
            for (int i = 0; i <= DEPTH; i++) begin
                chk("stall_data", log_q[i].data, {p[2*i], p[2*i+1]});
                chk("stall_x", log_q[i].x, (2 * i) % W);
                chk("stall_y", log_q[i].y, (2 * i) / W);
            end
        end
        chk("stall_idle", busy, 0);
        step(1, 0, 18'h0);
        chk("stall_ovf_clr", overflow, 0);

        // Frame restart discards the half word
        resp_en = 1; rmin = 1; rmax = 3;
        log_q.delete();
        p[0] = 18'h2AAAA; p[1] = 18'h15555; p[2] = 18'h3FFFF;
        for (int i = 0; i < 3; i++) step(0, 1, p[i]);
        step(1, 1, 18'h00001);
        step(0, 1, 18'h00002);
        drain(100);
        chk("restart_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("restart_w0", log_q[0].data, {18'h2AAAA, 18'h15555});
            chk("restart_w0_x", log_q[0].x, 0);
            chk("restart_w1", log_q[1].data, {18'h00001, 18'h00002});
            chk("restart_w1_x", log_q[1].x, 0);
            chk("restart_w1_y", log_q[1].y, 0);
        end

        // Reset mid-WAIT
        resp_en = 0; done_wr = 0;
        step(0, 1, 18'h11111);
        step(0, 1, 18'h22222);
        step(0, 1, 18'h33333);
        idle(2);
        chk("midrst_pre_busy", busy, 1);
        reset = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_data", pixel_write, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_wr", wr, 1);
        idle(2);
        reset = 1;
        log_q.delete();
        idle(5);
        chk("midrst_noflag", log_q.size(), 0);
        step(0, 1, 18'h0F0F0);
        step(0, 1, 18'h30303);
        idle(2);
        chk("midrst_new", log_q.size(), 1);
        if (log_q.size() == 1) chk("midrst_new_x", log_q[0].x, 0);
        done_wr = 1;
        step(0, 0, 18'h0);

        // Random traffic, short then long memory latency
        resp_en = 1;
        for (int ph = 0; ph < 2; ph++) begin
            rmin = 1; rmax = (ph == 0) ? 3 : 12;
            for (int c = 0; c < 1500; c++) begin
                step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 70, 18'($urandom));
            end
            drain(200);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
